cu_simple_instr_fetch: RTL

CU_SIMPLE_INSTR_FETCH -- requirements
Module: cu_simple_instr_fetch

---
 rtl/cu_simple_instr_fetch.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cu_simple_instr_fetch.sv
// ============================================================================
// cu_simple_instr_fetch
//
// Purpose:
//   Simple non-pipelined instruction fetch unit. One instruction is in flight
//   at a time: the PC is put on the instruction memory bus for one cycle, the
//   returned word is captured one cycle later, and it is then presented to the
//   decoder until the decoder accepts it. While an instruction is presented,
//   the unit also accepts jump targets (unconditional) and branch targets
//   paired with a condition token, and updates the PC accordingly.
//
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   enable             - fetching starts/continues only while high
//   imem_rd            - instruction memory read strobe (one cycle per fetch)
//   imem_addr          - instruction memory read address (current PC)
//   imem_rdata         - read data, valid the cycle after imem_rd
//   raw_instr_*        - instruction producer towards the decoder
//                        (data/valid out, ack in)
//   jump_*             - unconditional jump target consumer
//                        (ptr/valid in, ack out)
//   branch_*           - conditional branch target consumer
//                        (ptr/valid in, ack out)
//   cond_*             - branch condition token consumer
//                        (data/valid in, ack out)
//   retired            - count of instructions accepted by the decoder
// ============================================================================
module cu_simple_instr_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,

    output logic                  imem_rd,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,

    output logic [DATA_WIDTH-1:0] raw_instr_data,
    output logic                  raw_instr_valid,
    input  logic                  raw_instr_ack,

    input  logic [DATA_WIDTH-1:0] jump_ptr,
    input  logic                  jump_valid,
    output logic                  jump_ack,

    input  logic [DATA_WIDTH-1:0] branch_ptr,
    input  logic                  branch_valid,
    output logic                  branch_ack,

    input  logic [DATA_WIDTH-1:0] cond_data,
    input  logic                  cond_valid,
    output logic                  cond_ack,

    output logic [31:0]           retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_PRESENT
    } state_t;

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [31:0]           r_retired;
    logic                  r_imemRd;
    logic                  r_rawValid;

    logic                  w_inPresent;
    logic                  w_jumpAck;
    logic                  w_branchAck;
    logic                  w_condTrue;
    logic                  w_retire;
    logic [PC_WIDTH-1:0]   w_pcInc;
    logic                  w_unusedPtrHigh;

    // Handshake decode. Jump and branch acceptance only happen while an
    // instruction is presented and are independent of the decoder's ack.
    // A jump always beats a branch, and a branch is only taken when its
    // condition token is available in the same cycle so both are consumed
    // together. Reset masks the acks so nothing is reported as consumed on
    // a cycle whose state update is being discarded.
    always_comb begin
        w_inPresent = (r_state == S_PRESENT);
        w_jumpAck   = w_inPresent && jump_valid && !reset;
        w_branchAck = w_inPresent && branch_valid && cond_valid && !jump_valid && !reset;
        w_condTrue  = |cond_data;
        w_retire    = r_rawValid && raw_instr_ack;
        w_pcInc     = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end

    // Only the low PC_WIDTH bits of the target pointers form an address;
    // the upper bits are intentionally ignored.
    assign w_unusedPtrHigh = ^{jump_ptr[DATA_WIDTH-1:PC_WIDTH],
                               branch_ptr[DATA_WIDTH-1:PC_WIDTH]};

    // Main controller: state sequencing, PC, instruction register, retired
    // counter and the registered strobes. The memory strobe is raised on
    // entry to FETCH and dropped on the following edge, and the presented
    // valid is raised on entry to PRESENT and dropped when the decoder takes
    // the instruction. Once a fetch has started, enable is not looked at
    // again until the instruction has been handed to the decoder.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_retired  <= '0;
            r_imemRd   <= 1'b0;
            r_rawValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state  <= S_FETCH;
                        r_imemRd <= 1'b1;
                    end
                end

                S_FETCH: begin
                    r_state  <= S_READ;
                    r_imemRd <= 1'b0;
                end

                S_READ: begin
                    r_ir       <= imem_rdata;
                    r_state    <= S_PRESENT;
                    r_rawValid <= 1'b1;
                end

                S_PRESENT: begin
                    // Control-flow redirection takes precedence over the
                    // sequential increment from the decoder's ack.
                    if (w_jumpAck) begin
                        r_pc <= jump_ptr[PC_WIDTH-1:0];
                    end else if (w_branchAck) begin
                        r_pc <= w_condTrue ? branch_ptr[PC_WIDTH-1:0] : w_pcInc;
                    end else if (raw_instr_ack) begin
                        r_pc <= w_pcInc;
                    end

                    if (w_retire) begin
                        r_retired  <= r_retired + 32'd1;
                        r_rawValid <= 1'b0;
                        if (enable) begin
                            r_state  <= S_FETCH;
                            r_imemRd <= 1'b1;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_imemRd   <= 1'b0;
                    r_rawValid <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping. The instruction bus reads as zero whenever nothing is
    // being presented so the decoder never sees a stale word.
    always_comb begin
        imem_rd         = r_imemRd;
        imem_addr       = r_pc;
        raw_instr_valid = r_rawValid;
        raw_instr_data  = r_rawValid ? r_ir : '0;
        jump_ack        = w_jumpAck;
        branch_ack      = w_branchAck;
        cond_ack        = w_branchAck;
        retired         = r_retired;
    end

endmodule
